// File: rtl/mac_seq.sv
// Sequential FIR multiply-accumulate engine: one tap product per cycle, then round/scale.
// Build option MAC_SAT_EN clamps the scaled result instead of wrapping it.
module mac_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int NUM_TAPS   = 8,
    parameter int Q_FORMAT   = COEF_WIDTH / 2,
    parameter int OUT_WIDTH  = DATA_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [DATA_WIDTH-1:0]   sampleIn,
    input  logic                           sampleValid,
    output logic                           sampleReady,
    input  logic                           coefWrEn,
    input  logic [$clog2(NUM_TAPS)-1:0]    coefAddr,
    input  logic signed [COEF_WIDTH-1:0]   coefData,
    output logic signed [OUT_WIDTH-1:0]    resultOut,
    output logic                           resultValid,
    input  logic                           resultReady,
    output logic                           busy
);

    localparam int IDX_W     = $clog2(NUM_TAPS);
    localparam int ACC_WIDTH = DATA_WIDTH + COEF_WIDTH + IDX_W;
    localparam int RW        = ACC_WIDTH + 1;
    localparam logic [RW-1:0] RND =
        (Q_FORMAT > 0) ? (RW'(1) << (Q_FORMAT - 1)) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_ROUND,
        S_OUTPUT
    } state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic                          w_ready;
    logic                          w_busy;
    logic                          w_accept;
    logic                          w_last;
    logic                          w_addr_ok;

    logic signed [DATA_WIDTH-1:0]  r_taps [NUM_TAPS];
    logic signed [COEF_WIDTH-1:0]  r_coef [NUM_TAPS];
    logic signed [ACC_WIDTH-1:0]   r_acc;
    logic [IDX_W-1:0]              r_idx;
    logic signed [OUT_WIDTH-1:0]   r_result;

    logic signed [DATA_WIDTH-1:0]  w_tap;
    logic signed [COEF_WIDTH-1:0]  w_coef;
    logic signed [ACC_WIDTH-1:0]   w_tap_ext;
    logic signed [ACC_WIDTH-1:0]   w_coef_ext;
    logic signed [ACC_WIDTH-1:0]   w_prod;
    logic signed [RW-1:0]          w_acc_ext;
    logic signed [RW-1:0]          w_rnd;
    logic signed [OUT_WIDTH-1:0]   w_res;

    assign w_accept  = w_ready & sampleValid;
    assign w_last    = (r_idx == IDX_W'(NUM_TAPS - 1));
    assign w_addr_ok = ({1'b0, coefAddr} < (IDX_W + 1)'(NUM_TAPS));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_busy  = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                w_busy  = 1'b0;
                w_ready = ~rst;
                if (w_ready && sampleValid) begin
                    w_next = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_last) begin
                    w_next = S_ROUND;
                end
            end
            S_ROUND: begin
                w_next = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (resultReady) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Both operands are sign-extended to full accumulator width before the multiply.
    assign w_tap      = r_taps[r_idx];
    assign w_coef     = r_coef[r_idx];
    assign w_tap_ext  = {{(ACC_WIDTH - DATA_WIDTH){w_tap[DATA_WIDTH-1]}}, w_tap};
    assign w_coef_ext = {{(ACC_WIDTH - COEF_WIDTH){w_coef[COEF_WIDTH-1]}}, w_coef};
    assign w_prod     = w_tap_ext * w_coef_ext;

    assign w_acc_ext  = {r_acc[ACC_WIDTH-1], r_acc};
    assign w_rnd      = w_acc_ext + RND;

`ifdef MAC_SAT_EN
    localparam logic signed [RW-1:0] SAT_MAX =
        {{(RW - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN =
        {{(RW - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    logic signed [RW-1:0] w_shf;

    assign w_shf = w_rnd >>> Q_FORMAT;

    always_comb begin
        w_res = w_shf[OUT_WIDTH-1:0];
        if (w_shf > SAT_MAX) begin
            w_res = SAT_MAX[OUT_WIDTH-1:0];
        end else if (w_shf < SAT_MIN) begin
            w_res = SAT_MIN[OUT_WIDTH-1:0];
        end
    end
`else
    assign w_res = OUT_WIDTH'(w_rnd >>> Q_FORMAT);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_idx    <= '0;
            r_result <= '0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                r_taps[k] <= '0;
                r_coef[k] <= '0;
            end
        end else begin
            if (r_state == S_IDLE && coefWrEn && w_addr_ok) begin
                r_coef[coefAddr] <= coefData;
            end
            if (w_accept) begin
                r_taps[0] <= sampleIn;
                for (int k = 1; k < NUM_TAPS; k++) begin
                    r_taps[k] <= r_taps[k-1];
                end
                r_acc <= '0;
                r_idx <= '0;
            end
            if (r_state == S_ACCUM) begin
                r_acc <= r_acc + w_prod;
                r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
            end
            if (r_state == S_ROUND) begin
                r_result <= w_res;
            end
        end
    end

    assign sampleReady = w_ready;
    assign busy        = w_busy;
    assign resultValid = (r_state == S_OUTPUT);
    assign resultOut   = r_result;

endmodule

// File: tb/tb_mac_seq.sv
// Scoreboard bench for mac_seq: a small FIR model predicts each result at sample accept.
// Define MAC_SAT_EN for both bench and RTL to check the clamping build.
module tb_mac_seq;

    localparam int NT = 8;
    localparam int Q  = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic signed [15:0]  sampleIn;
    logic                sampleValid;
    logic                sampleReady;
    logic                coefWrEn;
    logic [2:0]          coefAddr;
    logic signed [15:0]  coefData;
    logic signed [15:0]  resultOut;
    logic                resultValid;
    logic                resultReady;
    logic                busy;

    int checks   = 0;
    int failures = 0;

    logic [15:0] sb [$];
    longint      m_tap  [NT];
    longint      m_coef [NT];

    mac_seq dut (
        .clk         (clk),
        .rst         (rst),
        .sampleIn    (sampleIn),
        .sampleValid (sampleValid),
        .sampleReady (sampleReady),
        .coefWrEn    (coefWrEn),
        .coefAddr    (coefAddr),
        .coefData    (coefData),
        .resultOut   (resultOut),
        .resultValid (resultValid),
        .resultReady (resultReady),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_out();
        longint acc = 0;
        for (int i = 0; i < NT; i++) acc += m_coef[i] * m_tap[i];
        acc = (acc + (64'sd1 <<< (Q - 1))) >>> Q;
`ifdef MAC_SAT_EN
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
`endif
        return acc[15:0];
    endfunction

    task automatic do_reset();
        rst         = 1'b1;
        sampleValid = 1'b0;
        coefWrEn    = 1'b0;
        resultReady = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NT; i++) begin
            m_tap[i]  = 0;
            m_coef[i] = 0;
        end
        sb.delete();
    endtask

    task automatic write_coef(input int a, input logic signed [15:0] d);
        @(negedge clk);
        coefWrEn = 1'b1;
        coefAddr = 3'(a);
        coefData = d;
        m_coef[a] = longint'(d);
        @(negedge clk);
        coefWrEn = 1'b0;
    endtask

    task automatic accept_sample(input logic signed [15:0] s, input bit we,
                                 input int wa, input logic signed [15:0] wd,
                                 output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (sampleReady) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: sampleReady=%b required 1", sampleReady);
            return;
        end
        sampleValid = 1'b1;
        sampleIn    = s;
        if (we) begin
            coefWrEn = 1'b1;
            coefAddr = 3'(wa);
            coefData = wd;
            m_coef[wa] = longint'(wd);
        end
        @(negedge clk);
        sampleValid = 1'b0;
        coefWrEn    = 1'b0;
        for (int k = NT - 1; k > 0; k--) m_tap[k] = m_tap[k-1];
        m_tap[0] = longint'(s);
        sb.push_back(model_out());
    endtask

    task automatic wait_result(output logic [15:0] got, output int lat, output bit ok);
        ok  = 1'b0;
        lat = 0;
        while (!ok && lat < 60) begin
            if (resultValid) ok = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL result_timeout: resultValid=%b required 1", resultValid);
        end
        got = resultOut;
    endtask

    task automatic release_result();
        resultReady = 1'b1;
        @(negedge clk);
        resultReady = 1'b0;
    endtask

    task automatic run_one(input logic signed [15:0] s, output logic [15:0] got,
                           output int lat);
        bit ok;
        got = 'x;
        lat = -1;
        accept_sample(s, 1'b0, 0, 16'sd0, ok);
        if (!ok) return;
        wait_result(got, lat, ok);
        if (ok) release_result();
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        sampleValid = 1'b0;
        sampleIn    = '0;
        coefWrEn    = 1'b0;
        coefAddr    = '0;
        coefData    = '0;
        resultReady = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (sampleReady !== 1'b0 || busy !== 1'b0 || resultValid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: rdy=%b busy=%b vld=%b required 0 0 0",
                     sampleReady, busy, resultValid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (sampleReady !== 1'b1 || resultOut !== 16'sd0) begin
            failures++;
            $display("FAIL reset_release: rdy=%b out=%h required 1 0000",
                     sampleReady, resultOut);
        end
        for (int i = 0; i < NT; i++) begin
            m_tap[i]  = 0;
            m_coef[i] = 0;
        end
    endtask

    task automatic test_impulse();
        logic [15:0] got, exp, lit;
        int lat;
        do_reset();
        for (int i = 0; i < NT; i++) write_coef(i, 16'((i + 1) * 256));
        for (int n = 0; n <= NT; n++) begin
            run_one((n == 0) ? 16'sd1 : 16'sd0, got, lat);
            exp = sb.pop_front();
            lit = (n < NT) ? 16'(n + 1) : 16'h0;
            checks++;
            if (got !== exp || got !== lit) begin
                failures++;
                $display("FAIL impulse[%0d]: got %h required %h (model %h)", n, got, lit, exp);
            end
            checks++;
            if (lat !== NT + 1) begin
                failures++;
                $display("FAIL impulse_latency[%0d]: got %0d required %0d", n, lat, NT + 1);
            end
        end
    endtask

    task automatic test_rounding();
        logic [15:0] got, exp;
        logic [15:0] lit [3];
        logic signed [15:0] smp [3];
        int lat;
        smp = '{16'sd3, -16'sd3, 16'sd1};
        lit = '{16'h0002, 16'hFFFF, 16'h0001};
        for (int i = 1; i < NT; i++) write_coef(i, 16'sd0);
        write_coef(0, 16'sd128);
        for (int n = 0; n < 3; n++) begin
            run_one(smp[n], got, lat);
            exp = sb.pop_front();
            checks++;
            if (got !== exp || got !== lit[n]) begin
                failures++;
                $display("FAIL rounding[%0d]: got %h required %h (model %h)", n, got, lit[n], exp);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] got, exp;
        int lat;
        bit ok;
        accept_sample(16'sd5, 1'b0, 0, 16'sd0, ok);
        wait_result(got, lat, ok);
        exp = sb.pop_front();
        checks++;
        if (got !== exp || got !== 16'h0003) begin
            failures++;
            $display("FAIL bp_value: got %h required 0003 (model %h)", got, exp);
        end
        for (int c = 0; c < 10; c++) begin
            sampleValid = c[0];
            sampleIn    = 16'sd99;
            @(negedge clk);
            checks++;
            if (resultValid !== 1'b1 || resultOut !== exp ||
                sampleReady !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold[%0d]: vld=%b out=%h rdy=%b busy=%b required 1 %h 0 1",
                         c, resultValid, resultOut, sampleReady, busy, exp);
            end
        end
        sampleValid = 1'b0;
        resultReady = 1'b1;
        @(negedge clk);
        resultReady = 1'b0;
        checks++;
        if (resultValid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: vld=%b busy=%b required 0 0", resultValid, busy);
        end
        write_coef(0, 16'sd0);
        write_coef(1, 16'sd256);
        run_one(16'sd0, got, lat);
        exp = sb.pop_front();
        checks++;
        if (got !== exp || got !== 16'h0005) begin
            failures++;
            $display("FAIL bp_not_consumed: got %h required 0005 (model %h)", got, exp);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] got, exp, lit;
        logic signed [15:0] smp;
        int lat;
        for (int i = 0; i < NT; i++) write_coef(i, 16'sh7FFF);
        for (int p = 0; p < 2; p++) begin
            smp = (p == 0) ? 16'sh7FFF : 16'sh8000;
`ifdef MAC_SAT_EN
            lit = (p == 0) ? 16'h7FFF : 16'h8000;
`else
            lit = (p == 0) ? 16'hF800 : 16'h0400;
`endif
            for (int n = 0; n < NT; n++) begin
                run_one(smp, got, lat);
                exp = sb.pop_front();
                checks++;
                if (got !== exp || (n == NT - 1 && got !== lit)) begin
                    failures++;
                    $display("FAIL overflow[%0d][%0d]: got %h required %h (final %h)",
                             p, n, got, exp, lit);
                end
            end
        end
    endtask

    task automatic test_coef_gating();
        logic [15:0] got, exp;
        logic [15:0] lit [3];
        int lat;
        bit ok;
        lit = '{16'h0001, 16'h0002, 16'h0003};
        do_reset();
        for (int i = 0; i < NT; i++) write_coef(i, 16'((i + 1) * 256));
        accept_sample(16'sd1, 1'b0, 0, 16'sd0, ok);
        @(negedge clk);
        coefWrEn = 1'b1;
        coefAddr = 3'd2;
        coefData = 16'sh1000;
        repeat (2) @(negedge clk);
        coefWrEn = 1'b0;
        wait_result(got, lat, ok);
        release_result();
        for (int n = 0; n < 3; n++) begin
            if (n > 0) run_one(16'sd0, got, lat);
            exp = sb.pop_front();
            checks++;
            if (got !== exp || got !== lit[n]) begin
                failures++;
                $display("FAIL gating[%0d]: got %h required %h (model %h)", n, got, lit[n], exp);
            end
        end
        accept_sample(16'sd1, 1'b1, 0, 16'sh0200, ok);
        wait_result(got, lat, ok);
        release_result();
        exp = sb.pop_front();
        checks++;
        if (got !== exp || got !== 16'h0006) begin
            failures++;
            $display("FAIL coinciding_write: got %h required 0006 (model %h)", got, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] got, exp;
        int lat;
        bit ok;
        bit seen;
        accept_sample(16'sd7, 1'b0, 0, 16'sd0, ok);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NT; i++) begin
            m_tap[i]  = 0;
            m_coef[i] = 0;
        end
        sb.delete();
        #1;
        checks++;
        if (sampleReady !== 1'b1 || busy !== 1'b0 || resultValid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_release: rdy=%b busy=%b vld=%b required 1 0 0",
                     sampleReady, busy, resultValid);
        end
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (resultValid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL midreset_no_result: resultValid seen=%b required 0", seen);
        end
        for (int n = 0; n < 3; n++) begin
            run_one((n == 0) ? 16'sd1 : 16'sd0, got, lat);
            exp = sb.pop_front();
            checks++;
            if (got !== exp || got !== 16'h0000) begin
                failures++;
                $display("FAIL midreset_zero_coef[%0d]: got %h required 0000 (model %h)",
                         n, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_rounding();
        test_backpressure();
        test_overflow();
        test_coef_gating();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
